// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared encodings for the SPI shift datapath: datapath state
//             (IDLE/ACTIVE), the four SPI mode encodings and the default
//             word width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Default word length in bits.
  localparam int unsigned c_DEFAULT_WIDTH = 8;

  // Datapath state: IDLE while chip select is high, ACTIVE while it is low.
  localparam logic [0:0] c_ST_IDLE   = 1'b0;
  localparam logic [0:0] c_ST_ACTIVE = 1'b1;

  // SPI mode encodings {CPOL, CPHA}.
  localparam logic [1:0] c_SPI_MODE0 = 2'b00;
  localparam logic [1:0] c_SPI_MODE1 = 2'b01;
  localparam logic [1:0] c_SPI_MODE2 = 2'b10;
  localparam logic [1:0] c_SPI_MODE3 = 2'b11;

  // The datapath only cares about the clock phase bit of a mode.
  function automatic logic spi_mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_tx_buffer
//  Purpose  : One-entry transmit holding register with a valid/ready write
//             side. The shift datapath reads it at each word load; a read
//             always empties it.
//  Ports    : clk_i      - clock
//             reset_ni   - synchronous active-low reset
//             wr_data_i  - word to store
//             wr_valid_i - write request
//             wr_ready_o - buffer empty, write accepted this cycle
//             rd_i       - load strobe from the shift datapath
//             rd_data_o  - stored word
//             empty_o    - no word stored
//  Revision : 1.0 - initial release
// ============================================================================
module spi_tx_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             w_write;

  // Ready comes only from the registered fill state, so a write landing in the
  // same cycle as a load is kept for the following word rather than bypassed.
  assign w_write = wr_valid_i & ~full_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (rd_i) begin
      full_d = 1'b0;
    end
    if (w_write) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign wr_ready_o = ~full_q;
  assign empty_o    = ~full_q;
  assign rd_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/spi_shift_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : spi_shift_datapath
//  Purpose  : SPI slave shift datapath. Captures MOSI on sample pulses into a
//             receive shift register, drives MISO from a transmit shift
//             register advanced on shift pulses, and hands complete words to
//             and from valid/ready interfaces with sticky error flags.
//  Ports    : clk_i, reset_ni        - clock, synchronous active-low reset
//             cs_ni, cpha_i          - chip select (active low), clock phase
//             sample_i, shift_i      - edge pulses from the SPI edge FSM
//             mosi_i, miso_o         - serial data in / out
//             tx_data_i, tx_valid_i, tx_ready_o - transmit word write port
//             rx_data_o, rx_valid_o, rx_ready_i - received word read port
//             rx_overrun_o, tx_underrun_o, clear_err_i - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module spi_shift_datapath
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH     = c_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             cs_ni,
  input  logic             cpha_i,
  input  logic             sample_i,
  input  logic             shift_i,
  input  logic             mosi_i,
  output logic             miso_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_overrun_o,
  output logic             tx_underrun_o,
  input  logic             clear_err_i
);

  localparam int unsigned          c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0]   c_LAST_BIT = c_CNT_W'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic               cpha_q;
  logic [c_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic               pending_load_q, pending_load_d;
  logic [WIDTH-1:0]   rx_shreg_q, rx_shreg_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0]   tx_shreg_q, tx_shreg_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               tx_underrun_q, tx_underrun_d;

  logic               w_enter, w_exit, w_active;
  logic               w_sample, w_shift, w_word_done, w_load;
  logic               w_buf_empty;
  logic [WIDTH-1:0]   w_buf_data;
  logic [WIDTH-1:0]   w_rx_shifted, w_tx_shifted;
  logic               w_unused_rx_end;

  // --------------------------------------------------------------------------
  // Transmit holding buffer
  // --------------------------------------------------------------------------
  spi_tx_buffer #(
    .WIDTH (WIDTH)
  ) u_tx_buffer (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .wr_data_i  (tx_data_i),
    .wr_valid_i (tx_valid_i),
    .wr_ready_o (tx_ready_o),
    .rd_i       (w_load),
    .rd_data_o  (w_buf_data),
    .empty_o    (w_buf_empty)
  );

  // --------------------------------------------------------------------------
  // Bit ordering: both lines use the same direction
  // --------------------------------------------------------------------------
  if (MSB_FIRST) begin : g_msb_first
    assign w_rx_shifted = {rx_shreg_q[WIDTH-2:0], mosi_i};
    assign w_tx_shifted = {tx_shreg_q[WIDTH-2:0], 1'b0};
    assign miso_o       = tx_shreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign w_rx_shifted = {mosi_i, rx_shreg_q[WIDTH-1:1]};
    assign w_tx_shifted = {1'b0, tx_shreg_q[WIDTH-1:1]};
    assign miso_o       = tx_shreg_q[0];
  end

  // The receive bit that falls off the far end on each shift is never read.
  assign w_unused_rx_end = rx_shreg_q[WIDTH-1] ^ rx_shreg_q[0];

  // --------------------------------------------------------------------------
  // State machine: state register / next state / decoded outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:   if (!cs_ni) state_d = c_ST_ACTIVE;
      c_ST_ACTIVE: if (cs_ni)  state_d = c_ST_IDLE;
      default:     state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_enter  = 1'b0;
    w_exit   = 1'b0;
    w_active = 1'b0;
    case (state_q)
      c_ST_IDLE:   w_enter = ~cs_ni;
      c_ST_ACTIVE: begin
        w_exit   = cs_ni;
        w_active = ~cs_ni;
      end
      default: ;
    endcase
  end

  // Edge pulses only count while the transfer is in progress; the exit cycle
  // counts as already idle.
  assign w_sample    = w_active & sample_i;
  assign w_shift     = w_active & shift_i;
  assign w_word_done = w_sample & (bit_cnt_q == c_LAST_BIT);

  // cpha=0 preloads at frame start; otherwise a load replaces the shift that
  // follows a word boundary.
  assign w_load = (w_enter & ~cpha_q) | (w_shift & pending_load_q);

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d      = bit_cnt_q;
    pending_load_d = pending_load_q;
    rx_shreg_d     = rx_shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = rx_valid_q;
    tx_shreg_d     = tx_shreg_q;
    rx_overrun_d   = rx_overrun_q  & ~clear_err_i;
    tx_underrun_d  = tx_underrun_q & ~clear_err_i;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    // Aborted frame: drop the partial word but keep everything handed over.
    if (w_exit) begin
      bit_cnt_d      = '0;
      pending_load_d = 1'b0;
      rx_shreg_d     = '0;
    end

    if (w_enter && cpha_q) begin
      pending_load_d = 1'b1;
    end

    if (w_shift) begin
      if (pending_load_q) begin
        pending_load_d = 1'b0;
      end else begin
        tx_shreg_d = w_tx_shifted;
      end
    end

    if (w_load) begin
      if (w_buf_empty) begin
        tx_shreg_d    = '0;
        tx_underrun_d = 1'b1;
      end else begin
        tx_shreg_d = w_buf_data;
      end
    end

    if (w_sample) begin
      rx_shreg_d = w_rx_shifted;
      if (w_word_done) begin
        bit_cnt_d      = '0;
        rx_data_d      = w_rx_shifted;
        rx_valid_d     = 1'b1;
        // Set after the shift handling so a new boundary wins over a clear.
        pending_load_d = 1'b1;
        // A read completing in this same cycle frees the slot in time.
        if (rx_valid_q && !rx_ready_i) begin
          rx_overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cpha_q         <= 1'b0;
      bit_cnt_q      <= '0;
      pending_load_q <= 1'b0;
      rx_shreg_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_shreg_q     <= '0;
      rx_overrun_q   <= 1'b0;
      tx_underrun_q  <= 1'b0;
    end else begin
      // Clock phase is only allowed to change between frames.
      if (cs_ni) begin
        cpha_q <= cpha_i;
      end
      bit_cnt_q      <= bit_cnt_d;
      pending_load_q <= pending_load_d;
      rx_shreg_q     <= rx_shreg_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      tx_shreg_q     <= tx_shreg_d;
      rx_overrun_q   <= rx_overrun_d;
      tx_underrun_q  <= tx_underrun_d;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_shift_datapath
//  Purpose  : Self-checking bench for spi_shift_datapath (WIDTH=8, MSB first).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_shift_datapath;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       cpha = 1'b0;
  logic       sample = 1'b0;
  logic       shift = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_overrun;
  logic       tx_underrun;
  logic       clear_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the randomized frames
  logic       mbuf_full = 1'b0;
  logic [7:0] mbuf_val  = 8'h00;
  logic [7:0] cur       = 8'h00;
  logic       und_exp   = 1'b0;
  logic       ovr_exp   = 1'b0;
  logic       rx_unread = 1'b0;

  typedef struct {
    logic       ph;
    logic [7:0] tx;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic       exp_und;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  spi_shift_datapath #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .cs_ni         (cs_n),
    .cpha_i        (cpha),
    .sample_i      (sample),
    .shift_i       (shift),
    .mosi_i        (mosi),
    .miso_o        (miso),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .rx_ready_i    (rx_ready),
    .rx_overrun_o  (rx_overrun),
    .tx_underrun_o (tx_underrun),
    .clear_err_i   (clear_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_sample(input logic b);
    mosi = b; sample = 1'b1; tick(); sample = 1'b0;
  endtask

  task automatic pulse_shift();
    shift = 1'b1; tick(); shift = 1'b0;
  endtask

  task automatic write_tx(input logic [7:0] d);
    check("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
    tx_data = d; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  task automatic clr_err();
    clear_err = 1'b1; tick(); clear_err = 1'b0;
  endtask

  // One word on the bus. cpha=0: sample then shift per bit; cpha=1: shift
  // then sample. MISO is recorded when the bit should be valid for the master.
  task automatic xfer_word(input logic ph, input logic [7:0] m, output logic [7:0] seq,
                           output logic v_pre, output logic v_post);
    seq = 8'h00; v_pre = 1'b0; v_post = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ph) pulse_shift();
      seq[7-i] = miso;
      if (i == 7) v_pre = rx_valid;
      pulse_sample(m[7-i]);
      if (i == 7) v_post = rx_valid;
      if (!ph) pulse_shift();
    end
  endtask

  task automatic model_load();
    if (mbuf_full) begin
      cur = mbuf_val; mbuf_full = 1'b0;
    end else begin
      cur = 8'h00; und_exp = 1'b1;
    end
  endtask

  task automatic model_write(input logic [7:0] d);
    write_tx(d);
    mbuf_full = 1'b1; mbuf_val = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] seq, seq1, seq2;
    logic       vp, vq;

    vecs[0] = '{1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{1'b1, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 1'b0};
    vecs[2] = '{1'b0, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 1'b1};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 1'b0};

    // ---------------- reset values ----------------
    reset_n = 1'b0; tick(); tick();
    check("rst_miso",        {31'd0, miso},        32'd0);
    check("rst_rx_data",     {24'd0, rx_data},     32'd0);
    check("rst_rx_valid",    {31'd0, rx_valid},    32'd0);
    check("rst_tx_ready",    {31'd0, tx_ready},    32'd1);
    check("rst_rx_overrun",  {31'd0, rx_overrun},  32'd0);
    check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
    reset_n = 1'b1; tick();

    // ---------------- table-driven single-word frames ----------------
    for (int v = 0; v < 4; v++) begin
      cs_n = 1'b1; cpha = vecs[v].ph; tick();
      write_tx(vecs[v].tx); tick();
      cs_n = 1'b0; tick();
      xfer_word(vecs[v].ph, vecs[v].mosi_w, seq, vp, vq);
      check($sformatf("vec%0d_miso_seq", v), {24'd0, seq}, {24'd0, vecs[v].exp_miso});
      check($sformatf("vec%0d_rx_data", v), {24'd0, rx_data}, {24'd0, vecs[v].exp_rx});
      check($sformatf("vec%0d_rx_valid_before", v), {31'd0, vp}, 32'd0);
      check($sformatf("vec%0d_rx_valid_after", v), {31'd0, vq}, 32'd1);
      check($sformatf("vec%0d_overrun", v), {31'd0, rx_overrun}, 32'd0);
      check($sformatf("vec%0d_underrun", v), {31'd0, tx_underrun}, {31'd0, vecs[v].exp_und});
      pop_rx();
      check($sformatf("vec%0d_rx_valid_popped", v), {31'd0, rx_valid}, 32'd0);
      cs_n = 1'b1; tick();
      clr_err();
      check($sformatf("vec%0d_underrun_cleared", v), {31'd0, tx_underrun}, 32'd0);
    end

    // ---------------- overrun on back-to-back unread words ----------------
    cpha = 1'b0; tick();
    cs_n = 1'b0; tick();
    xfer_word(1'b0, 8'h11, seq, vp, vq);
    xfer_word(1'b0, 8'h22, seq, vp, vq);
    check("ovr_rx_data",  {24'd0, rx_data},    32'h22);
    check("ovr_rx_valid", {31'd0, rx_valid},   32'd1);
    check("ovr_flag",     {31'd0, rx_overrun}, 32'd1);
    clr_err();
    check("ovr_cleared",        {31'd0, rx_overrun}, 32'd0);
    check("ovr_valid_retained", {31'd0, rx_valid},   32'd1);
    pop_rx();
    cs_n = 1'b1; tick();
    clr_err();

    // ---------------- partial word aborted by cs high ----------------
    cs_n = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      pulse_sample(1'b1); pulse_shift();
    end
    check("abort_no_valid", {31'd0, rx_valid}, 32'd0);
    cs_n = 1'b1; tick(); tick();
    check("abort_still_no_valid", {31'd0, rx_valid}, 32'd0);
    cs_n = 1'b0; tick();
    xfer_word(1'b0, 8'h81, seq, vp, vq);
    check("abort_new_rx_data",     {24'd0, rx_data}, 32'h81);
    check("abort_no_early_valid",  {31'd0, vp},      32'd0);
    check("abort_valid_on_word",   {31'd0, vq},      32'd1);
    check("abort_no_overrun",      {31'd0, rx_overrun}, 32'd0);
    pop_rx();
    cs_n = 1'b1; tick();
    clr_err();

    // ---------------- underrun with same-cycle write ----------------
    write_tx(8'h33);
    cs_n = 1'b0; tick();
    seq = 8'h00;
    for (int i = 0; i < 8; i++) begin
      seq[7-i] = miso;
      pulse_sample(1'b0);
      if (i == 7) begin
        check("und_clear_before_boundary", {31'd0, tx_underrun}, 32'd0);
        tx_data = 8'h5A; tx_valid = 1'b1;
      end
      pulse_shift();
      tx_valid = 1'b0;
    end
    check("und_word0_seq",   {24'd0, seq},         32'h33);
    check("und_flag_set",    {31'd0, tx_underrun}, 32'd1);
    check("und_write_kept",  {31'd0, tx_ready},    32'd0);
    xfer_word(1'b0, 8'h00, seq1, vp, vq);
    xfer_word(1'b0, 8'h00, seq2, vp, vq);
    check("und_zero_word",   {24'd0, seq1}, 32'h00);
    check("und_next_word",   {24'd0, seq2}, 32'h5A);
    pop_rx();
    cs_n = 1'b1; tick();
    clr_err();

    // ---------------- reset in the middle of a word ----------------
    cs_n = 1'b0; tick();                      // loads from empty buffer
    xfer_word(1'b0, 8'hC9, seq, vp, vq);
    write_tx(8'h9C);
    xfer_word(1'b0, 8'h3A, seq, vp, vq);      // unread -> overrun; loads 9C
    write_tx(8'h12);
    pulse_sample(1'b1); pulse_sample(1'b0);
    check("pre_rst_miso",     {31'd0, miso},        32'd1);
    check("pre_rst_rx_valid", {31'd0, rx_valid},    32'd1);
    check("pre_rst_tx_ready", {31'd0, tx_ready},    32'd0);
    check("pre_rst_flags",    {30'd0, rx_overrun, tx_underrun}, 32'd3);
    reset_n = 1'b0; sample = 1'b1; shift = 1'b1; mosi = 1'b1; rx_ready = 1'b1;
    tick();
    sample = 1'b0; shift = 1'b0; rx_ready = 1'b0;
    check("mid_rst_miso",        {31'd0, miso},        32'd0);
    check("mid_rst_rx_data",     {24'd0, rx_data},     32'd0);
    check("mid_rst_rx_valid",    {31'd0, rx_valid},    32'd0);
    check("mid_rst_tx_ready",    {31'd0, tx_ready},    32'd1);
    check("mid_rst_rx_overrun",  {31'd0, rx_overrun},  32'd0);
    check("mid_rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
    reset_n = 1'b1; cs_n = 1'b1; tick(); tick();

    // ---------------- randomized frames vs. reference model ----------------
    mbuf_full = 1'b0; und_exp = 1'b0; ovr_exp = 1'b0; rx_unread = 1'b0;
    for (int f = 0; f < 24; f++) begin
      logic       ph;
      logic [7:0] mw;
      int         nw;
      ph = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      cpha = ph; cs_n = 1'b1; tick(); tick();
      check("rnd_tx_ready_idle", {31'd0, tx_ready}, {31'd0, ~mbuf_full});
      if (!mbuf_full && $urandom_range(0, 3) != 0) model_write(8'($urandom_range(0, 255)));
      cs_n = 1'b0; tick();
      if (!ph) model_load();
      for (int w = 0; w < nw; w++) begin
        mw = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
          if (ph) begin
            pulse_shift();
            if (i == 0) model_load();
          end
          check($sformatf("rnd_f%0d_w%0d_miso_b%0d", f, w, i), {31'd0, miso}, {31'd0, cur[7-i]});
          if (i == 3 && !mbuf_full && $urandom_range(0, 2) != 0)
            model_write(8'($urandom_range(0, 255)));
          if (i == 5 && $urandom_range(0, 1) == 1) begin
            pop_rx();
            rx_unread = 1'b0;
            check("rnd_rx_popped", {31'd0, rx_valid}, 32'd0);
          end
          if ($urandom_range(0, 3) == 0) tick();
          pulse_sample(mw[7-i]);
          if (!ph) begin
            pulse_shift();
            if (i == 7) model_load();
          end
        end
        if (rx_unread) ovr_exp = 1'b1;
        rx_unread = 1'b1;
        check($sformatf("rnd_f%0d_w%0d_rx_data", f, w), {24'd0, rx_data}, {24'd0, mw});
        check("rnd_rx_valid",    {31'd0, rx_valid},    32'd1);
        check("rnd_rx_overrun",  {31'd0, rx_overrun},  {31'd0, ovr_exp});
        check("rnd_tx_underrun", {31'd0, tx_underrun}, {31'd0, und_exp});
      end
      cs_n = 1'b1; tick();
      if ($urandom_range(0, 1) == 1) begin
        pop_rx();
        rx_unread = 1'b0;
      end
      check("rnd_rx_valid_idle", {31'd0, rx_valid}, {31'd0, rx_unread});
      if ($urandom_range(0, 2) != 0) begin
        clr_err();
        und_exp = 1'b0; ovr_exp = 1'b0;
        check("rnd_flags_cleared", {30'd0, rx_overrun, tx_underrun}, 32'd0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_shift_datapath.md
SPI_SHIFT_DATAPATH -- requirements
Module: spi_shift_datapath

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (>=2).
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB first on both lines, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cs  input  1  chip select, active-low; high = bus idle.
REQ-006 cpha  input  1  0 = sample-first modes (0/2); 1 = shift-first modes (1/3); sampled only while cs high.
REQ-007 sample  input  1  one-cycle pulse from the SPI edge FSM: capture mosi now.
REQ-008 shift  input  1  one-cycle pulse from the SPI edge FSM: advance miso now.
REQ-009 mosi  input  1  serial data in, synchronised upstream.
REQ-010 miso  output  1  serial data out.
REQ-011 tx_data  input  WIDTH  next word to transmit.
REQ-012 tx_valid / tx_ready  input / output  1 / 1  write handshake into the one-entry TX buffer.
REQ-013 rx_data  output  WIDTH  last received word.
REQ-014 rx_valid / rx_ready  output / input  1 / 1  read handshake for rx_data.
REQ-015 rx_overrun, tx_underrun  output  1 each  sticky error flags.
REQ-016 clear_err  input  1  clears both error flags.

Function
REQ-017 States IDLE (cs high) and ACTIVE (cs low); IDLE->ACTIVE on the cycle cs is sampled low, ACTIVE->IDLE on the cycle cs is sampled high.
REQ-018 sample and shift are ignored in IDLE; in ACTIVE they act independently and may coincide.
REQ-019 On sample: mosi enters rx_shreg (at bit 0 with left shift if MSB_FIRST=1, else at bit WIDTH-1 with right shift); bit_cnt increments.
REQ-020 On sample with bit_cnt==WIDTH-1: bit_cnt wraps to 0; rx_data takes the completed word and rx_valid is 1 on the next cycle; pending_load is set.
REQ-021 rx_valid holds until a cycle with rx_valid & rx_ready; a word completing while rx_valid is still 1 overwrites rx_data, keeps rx_valid 1 and sets rx_overrun.
REQ-022 A word completing in the same cycle as rx_valid & rx_ready produces no overrun.
REQ-023 miso = tx_shreg[WIDTH-1] if MSB_FIRST=1, else tx_shreg[0]; registered source only, no combinational path from inputs.
REQ-024 On shift with pending_load=0: tx_shreg shifts one place toward the miso bit, filling with 0.
REQ-025 On shift with pending_load=1: tx_shreg loads from the TX buffer instead of shifting; pending_load clears.
REQ-026 On IDLE->ACTIVE: cpha=0 loads tx_shreg from the TX buffer immediately; cpha=1 sets pending_load only.
REQ-027 TX buffer: tx_ready = buffer empty; a write happens on tx_valid & tx_ready; a load empties it.
REQ-028 A load from an empty buffer loads all zeros and sets tx_underrun; a write in the same cycle is stored for the next word, with no bypass.
REQ-029 ACTIVE->IDLE mid-word: partial RX bits are discarded; bit_cnt=0; pending_load=0; rx_data, rx_valid, TX buffer and tx_shreg are unchanged.
REQ-030 clear_err clears the flags; an error event in the same cycle wins and the flag stays 1.

Reset
REQ-031 While reset=0 at a clock edge: state=IDLE, bit_cnt=0, pending_load=0, rx_shreg=0, tx_shreg=0, TX buffer empty.
REQ-032 Reset output values: miso=0, rx_data=0, rx_valid=0, tx_ready=1, rx_overrun=0, tx_underrun=0.
REQ-033 Reset mid-transfer takes effect in the same clock edge and overrides all other events.

Structure
REQ-034 Package spi_pkg holds the IDLE/ACTIVE state encodings, the SPI mode encodings 00-11 and the default WIDTH.
REQ-035 The TX holding register with its valid/ready logic is the sub-module spi_tx_buffer; everything else stays in spi_shift_datapath.

Verification
REQ-036 cpha=0, MSB_FIRST=1, TX buffer preloaded 0xA5, cs low, 8 sample/shift pairs with mosi bits 0x3C -> miso sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid=1 one cycle after the 8th sample.
REQ-037 Two back-to-back words 0x11 then 0x22 with rx_ready held 0 -> rx_data=0x22, rx_valid=1, rx_overrun=1; clear_err pulse -> rx_overrun=0.
REQ-038 Word boundary with the TX buffer empty -> next word on miso is 0x00 and tx_underrun=1; tx_valid with 0x5A in the same cycle -> 0x5A is sent on the following word.
REQ-039 cpha=1, buffer 0xC3 -> the first shift loads, no shift-out; miso sequence 1,1,0,0,0,0,1,1.
REQ-040 cs high after 3 samples, then a new full 8-bit frame 0x81 -> rx_data=0x81, no spurious rx_valid from the partial word.
REQ-041 reset=0 asserted mid-word -> all outputs take their reset values on the next edge and tx_ready=1.
